smc_cfg_apb_if: RTL
===================

// Module: smc_cfg_apb_if
// PURPOSE
//  APB slave front-end for the SMC configuration register space. Decodes APB
//  transfers, drives selreg to the config register block, and returns its
//  32-bit read data on prdata with a registered pready/pslverr handshake.
//  Sits between the peripheral APB bridge and the read-only SMC config register.
// PARAMETERS
//  ADDR_W       8      width of paddr
//  CFG_ADDR     8'h00  byte address of the SMC config register
//  WAIT_STATES  1      extra ACCESS cycles before pready (0..15)
// PORTS
//  hclk         in   1       system clock, all logic on rising edge
//  n_sys_reset  in   1       asynchronous active-low reset
//  psel         in   1       APB select
//  penable      in   1       APB enable (ACCESS phase)
//  pwrite       in   1       1 = write, 0 = read
//  paddr        in   ADDR_W  APB byte address
//  rdata        in   32      read data returned by config register (0 when !selreg)
//  selreg       out  1       select to config register (read hit, in ACCESS)
//  prdata       out  32      APB read data, valid only while pready=1
//  pready       out  1       transfer complete, high exactly one cycle
//  pslverr      out  1       error response, qualified by pready
//  err_cnt      out  8       saturating count of error responses
// BEHAVIOUR
//  Reset: state=IDLE; selreg, pready, pslverr = 0; prdata = 0; err_cnt = 0;
//   wait counter = 0. Reset mid-transfer aborts it with no pready.
//  FSM states IDLE, ACCESS, DONE:
//   IDLE:   psel & !penable at edge -> ACCESS; latch paddr, pwrite; cnt=WAIT_STATES.
//   ACCESS: psel=0 at edge -> IDLE (aborted; no pready, no err_cnt change).
//           psel & penable & cnt!=0 -> cnt-1, stay.
//           psel & penable & cnt==0 -> DONE; register pready=1, prdata, pslverr.
//           psel & !penable -> stay, cnt unchanged (bridge not yet in ACCESS).
//   DONE:   pready=1 for this one cycle; next edge clears pready, pslverr, prdata.
//           If psel & !penable at that edge -> ACCESS (back-to-back, new latch);
//           else -> IDLE.
//  Latency: from SETUP cycle, pready rises WAIT_STATES+2 cycles later
//   (WAIT_STATES=0 gives one low ACCESS cycle, then pready).
//  Decode (on latched values): hit = (addr[ADDR_W-1:2]==CFG_ADDR[ADDR_W-1:2])
//   & (addr[1:0]==2'b00).
//  selreg = 1 only in ACCESS when hit & !write; 0 in IDLE/DONE.
//  Response at ACCESS->DONE edge:
//   read hit           -> prdata=rdata, pslverr=0
//   write to CFG_ADDR  -> prdata=0, pslverr=1 (register is read-only, no effect)
//   unmapped/misaligned-> prdata=0, pslverr=1
//  err_cnt increments by 1 on each pslverr=1 response; saturates at 8'hFF.
//  paddr/pwrite changes during ACCESS are ignored (latched in IDLE/DONE only).
//  pready never asserts without a preceding latched SETUP.
// TESTING
//  1 WAIT_STATES=1, read paddr=0x00, rdata=32'hC000_0001 -> pready high 3 cycles
//    after SETUP, prdata=32'hC000_0001, pslverr=0, selreg high 2 cycles.
//  2 Write paddr=0x00 pwdata=any -> pready with pslverr=1, prdata=0, selreg
//    never high, err_cnt 0->1.
//  3 Read paddr=0x04 then paddr=0x01 -> both pslverr=1, prdata=0, err_cnt=2.
//  4 Back-to-back reads of 0x00 with SETUP in DONE cycle -> no IDLE cycle,
//    two pready pulses spaced WAIT_STATES+2 cycles, both prdata=rdata.
//  5 Drop psel mid-ACCESS -> IDLE, pready stays 0, err_cnt unchanged; assert
//    n_sys_reset=0 mid-ACCESS -> all outputs 0 asynchronously.
//  6 Force 256 error transfers -> err_cnt holds 8'hFF on 256th and later.

Source files
------------

// File: rtl/smc_cfg_apb_if.sv
// APB slave front-end for the read-only SMC config register: decodes transfers,
// selects the register on read hits, and returns a registered pready/pslverr response.
module smc_cfg_apb_if #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] CFG_ADDR    = '0,
  parameter int                WAIT_STATES = 1
) (
  input  logic              hclk,
  input  logic              n_sys_reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       rdata,
  output logic              selreg,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [3:0]        cnt_q;
  logic              pready_q;
  logic              pslverr_q;
  logic [31:0]       prdata_q;
  logic [7:0]        err_cnt_q;
  logic [7:0]        err_cnt_d;
  logic              hit;
  logic              setup;

  // Only the word-aligned CFG_ADDR is mapped; every other offset is an error.
  assign hit = (addr_q[ADDR_W-1:2] == CFG_ADDR[ADDR_W-1:2]) && (addr_q[1:0] == 2'b00);

  assign setup     = psel && !penable;
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

  always_ff @(posedge hclk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          if (setup) begin
            state_q <= ST_ACCESS;
            addr_q  <= paddr;
            write_q <= pwrite;
            cnt_q   <= WAIT_INIT;
          end
        end
        ST_ACCESS: begin
          if (!psel) begin
            state_q <= ST_IDLE;
          end else if (penable) begin
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              state_q  <= ST_DONE;
              pready_q <= 1'b1;
              if (hit && !write_q) begin
                prdata_q  <= rdata;
                pslverr_q <= 1'b0;
              end else begin
                prdata_q  <= '0;
                pslverr_q <= 1'b1;
                err_cnt_q <= err_cnt_d;
              end
            end
          end
        end
        ST_DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          // A SETUP seen during the response cycle starts the next transfer directly.
          if (setup) begin
            state_q <= ST_ACCESS;
            addr_q  <= paddr;
            write_q <= pwrite;
            cnt_q   <= WAIT_INIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign selreg  = (state_q == ST_ACCESS) && hit && !write_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;
  assign err_cnt = err_cnt_q;

endmodule
